// File: rtl/and_gate_seq_pkg.sv
// Shared types and helpers for the AND-gate stimulus sequencer.
package and_gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    localparam int MAX_WIDTH       = 8;
    localparam int DEF_WIDTH       = 3;
    localparam int DEF_HOLD_CYCLES = 4;

    // Sweep-order mapping: identity for binary, reflected Gray otherwise.
    function automatic logic [MAX_WIDTH-1:0] order_vec(input logic [MAX_WIDTH-1:0] idx,
                                                       input logic gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    function automatic logic expected_and(input logic [MAX_WIDTH-1:0] v, input int width);
        logic r;
        r = 1'b1;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) r = r & v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_vector_counter.sv
// Vector index and hold counter; drives the registered gate input vector
// and flags the sample edge and the final vector.
module gate_vector_counter
    import and_gate_seq_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GRAY        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             run_i,
    output logic [WIDTH-1:0] vec_o,
    output logic             sample_o,
    output logic             last_o
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [WIDTH-1:0] index_q, index_d;
    logic [7:0]       hold_q, hold_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic             vec_live;

    assign sample_o = run_i && (hold_q == HOLD_LAST);
    assign last_o   = (index_q == {WIDTH{1'b1}});
    assign vec_o    = vec_q;

    always_comb begin
        index_d  = index_q;
        hold_d   = hold_q;
        vec_live = 1'b0;
        if (load_i) begin
            index_d  = '0;
            hold_d   = '0;
            vec_live = 1'b1;
        end else if (run_i) begin
            vec_live = 1'b1;
            if (sample_o) begin
                hold_d = '0;
                // the final sample returns the gate inputs to zero for DONE
                if (last_o) vec_live = 1'b0;
                else        index_d  = index_q + WIDTH'(1);
            end else begin
                hold_d = hold_q + 8'd1;
            end
        end
        vec_d = vec_live ? WIDTH'(order_vec(8'(index_d), GRAY != 0)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q <= '0;
            hold_q  <= '0;
            vec_q   <= '0;
        end else begin
            index_q <= index_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: rtl/and_gate_sequencer.sv
// Sweeps a WIDTH-input AND gate through every input combination and scores its output.
// IDLE | wait for start    APPLY | hold and sample vectors    DONE | one-cycle done pulse
module and_gate_sequencer
    import and_gate_seq_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GRAY        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] vec,
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] first_fail,
    output logic             pass
);

    seq_state_e       state_q, state_d;
    logic [WIDTH:0]   err_q, err_d;
    logic             fail_q, fail_d;
    logic [WIDTH-1:0] first_q, first_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load, run, sample, last, miss;

    assign load = (state_q == IDLE) && start;
    assign run  = (state_q == APPLY);

    gate_vector_counter #(
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (HOLD_CYCLES),
        .GRAY        (GRAY)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .run_i    (run),
        .vec_o    (vec),
        .sample_o (sample),
        .last_o   (last)
    );

    assign miss = (z_in != expected_and(8'(vec), WIDTH));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        fail_d  = fail_q;
        first_d = first_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    err_d   = '0;
                    fail_d  = 1'b0;
                    first_d = '0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                if (sample) begin
                    if (miss) begin
                        err_d = err_q + (WIDTH+1)'(1);
                        if (!fail_q) begin
                            fail_d  = 1'b1;
                            first_d = vec;
                        end
                    end
                    if (last) begin
                        state_d = DONE;
                        // registered with the DONE entry so pass is valid alongside done
                        pass_d  = (err_d == '0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == APPLY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= '0;
            fail_q  <= 1'b0;
            first_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err_count  = err_q;
    assign fail_valid = fail_q;
    assign first_fail = first_q;
    assign pass       = pass_q;

endmodule
